// File: rtl/convergence_check_controller.sv
// Sequencer for the k-means convergence check: clears the counter, walks the centroid index
// in lock-step with the new-means block, then decides between finishing and another pass.
module convergence_check_controller #(
  parameter int unsigned centroid_num = 8,
  parameter int unsigned iter_width   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [iter_width-1:0] max_iter,
  input  logic                  new_centroid_valid,
  input  logic                  has_converged,
  input  logic                  iter_done,
  output logic [2:0]            cent_num,
  output logic                  convergence_reg_en,
  output logic                  convergence_reg_reset,
  output logic                  iter_start,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic                  timeout,
  output logic [iter_width-1:0] iter_count
);

  localparam logic [2:0] LastCent = 3'(centroid_num - 1);
  localparam logic [iter_width-1:0] IterMax = '1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StEval,
    StSettle,
    StSample,
    StNext,
    StWaitIter,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            cent_q, cent_d;
  logic [iter_width-1:0] limit_q, limit_d;
  logic [iter_width-1:0] iter_q, iter_d;
  logic [iter_width-1:0] iter_inc;
  logic                  conv_q, conv_d;
  logic                  to_q, to_d;
  logic                  done_q, done_d;
  logic                  is_q, is_d;
  logic                  rr_q, rr_d;

  assign iter_inc = (iter_q == IterMax) ? iter_q : iter_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cent_d  = cent_q;
    limit_d = limit_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    to_d    = to_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          limit_d = (max_iter == '0) ? iter_width'(1) : max_iter;
          iter_d  = '0;
          conv_d  = 1'b0;
          to_d    = 1'b0;
          cent_d  = 3'd0;
          state_d = StClear;
        end
      end
      StClear: begin
        cent_d  = 3'd0;
        state_d = StEval;
      end
      StEval: begin
        if (new_centroid_valid) begin
          if (cent_q == LastCent) begin
            state_d = StSettle;
          end else begin
            cent_d = cent_q + 3'd1;
          end
        end
      end
      StSettle: state_d = StSample;
      StSample: begin
        iter_d = iter_inc;
        // A convergence on the limit iteration is reported as converged, not timeout.
        if (has_converged) begin
          conv_d  = 1'b1;
          state_d = StDone;
        end else if (iter_inc == limit_q) begin
          to_d    = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StNext;
        end
      end
      StNext: begin
        cent_d  = 3'd0;
        state_d = StWaitIter;
      end
      StWaitIter: begin
        if (iter_done) state_d = StClear;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pulse outputs are registered from the next state so they line up with their state.
  assign done_d = (state_d == StDone);
  assign is_d   = (state_d == StNext);
  assign rr_d   = (state_d != StClear);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cent_q  <= 3'd0;
      limit_q <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      to_q    <= 1'b0;
      done_q  <= 1'b0;
      is_q    <= 1'b0;
      rr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cent_q  <= cent_d;
      limit_q <= limit_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
      to_q    <= to_d;
      done_q  <= done_d;
      is_q    <= is_d;
      rr_q    <= rr_d;
    end
  end

  assign cent_num              = cent_q;
  assign convergence_reg_en    = (state_q == StEval) && new_centroid_valid;
  assign convergence_reg_reset = rr_q;
  assign iter_start            = is_q;
  assign busy                  = (state_q != StIdle);
  assign done                  = done_q;
  assign converged             = conv_q;
  assign timeout               = to_q;
  assign iter_count            = iter_q;

endmodule

// File: tb/tb_convergence_check_controller.sv
// Directed bench: cycle table for a single converging pass, then multi-pass corner sequences.
module tb_convergence_check_controller;

  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] max_iter;
  logic          new_centroid_valid;
  logic          has_converged;
  logic          iter_done;
  logic [2:0]    cent_num;
  logic          convergence_reg_en;
  logic          convergence_reg_reset;
  logic          iter_start;
  logic          busy;
  logic          done;
  logic          converged;
  logic          timeout;
  logic [IW-1:0] iter_count;

  convergence_check_controller #(
    .centroid_num(8),
    .iter_width  (IW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .max_iter             (max_iter),
    .new_centroid_valid   (new_centroid_valid),
    .has_converged        (has_converged),
    .iter_done            (iter_done),
    .cent_num             (cent_num),
    .convergence_reg_en   (convergence_reg_en),
    .convergence_reg_reset(convergence_reg_reset),
    .iter_start           (iter_start),
    .busy                 (busy),
    .done                 (done),
    .converged            (converged),
    .timeout              (timeout),
    .iter_count           (iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, valid, hconv, idone;
    logic [2:0] cent;
    logic       en, rr, is, busy, done, conv, to;
    logic [7:0] ic;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int s, v, h, d, c, e, r, i, b, dn, cv, t, ic);
    vec_t x;
    x.start = 1'(s);  x.valid = 1'(v);  x.hconv = 1'(h);  x.idone = 1'(d);
    x.cent  = 3'(c);  x.en    = 1'(e);  x.rr    = 1'(r);  x.is    = 1'(i);
    x.busy  = 1'(b);  x.done  = 1'(dn); x.conv  = 1'(cv); x.to    = 1'(t);
    x.ic    = 8'(ic);
    return x;
  endfunction

  // Runs one full job from IDLE; stimulus only, counts are checked by the caller.
  task automatic run(input int mi, input int conv_iter, input int vper, input bit misuse,
                     output int n_is, output int n_clr, output int n_en, output int lat);
    int  cyc = 0;
    int  idc = -1;
    int  last_en = 0;
    bit  fin = 1'b0;
    bit  mis_done = 1'b0;
    n_is = 0; n_clr = 0; n_en = 0; lat = -1;
    max_iter = IW'(mi);
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      start              = (cyc == 0);
      new_centroid_valid = ((cyc % vper) == 0);
      has_converged      = (conv_iter != 0) && (n_is + 1 == conv_iter);
      iter_done          = (idc == 0);
      if (idc >= 0) idc--;
      if (misuse && !mis_done && n_en == 3) begin
        start     = 1'b1;
        iter_done = 1'b1;
        mis_done  = 1'b1;
      end
      #1;
      if (convergence_reg_en) begin
        chk("cent_num_step", 32'(cent_num), 32'(n_en % 8));
        n_en++;
        last_en = cyc;
      end
      if (!convergence_reg_reset) n_clr++;
      if (iter_start) begin
        n_is++;
        idc = 4;
      end
      if (done) begin
        fin = 1'b1;
        lat = cyc - last_en;
        if (misuse) start = 1'b1;
      end
      cyc++;
    end
    if (!fin) chk("done_within_budget", 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0; new_centroid_valid = 1'b0; has_converged = 1'b0; iter_done = 1'b0;
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  vec_t tbl[15];
  int   n_is, n_clr, n_en, lat;
  int   idc;
  bit   found;

  initial begin
    rst = 1'b1; start = 1'b0; max_iter = '0; new_centroid_valid = 1'b0;
    has_converged = 1'b0; iter_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single pass, max_iter=10, converging at the first sample; stray inputs must be ignored.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      tbl[2+k] = mk((k == 4) ? 1 : 0, 1, 0, (k == 3) ? 1 : 0, k, 1, 1, 0, 1, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 7, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 7, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 7, 0, 1, 0, 1, 1, 1, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 1, 0, 1);
    tbl[14] = mk(0, 0, 0, 1, 7, 0, 1, 0, 0, 0, 1, 0, 1);
    max_iter = IW'(10);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      start = tbl[i].start; new_centroid_valid = tbl[i].valid;
      has_converged = tbl[i].hconv; iter_done = tbl[i].idone;
      #1;
      chk($sformatf("t%0d.cent", i), 32'(cent_num), 32'(tbl[i].cent));
      chk($sformatf("t%0d.en", i), 32'(convergence_reg_en), 32'(tbl[i].en));
      chk($sformatf("t%0d.rr", i), 32'(convergence_reg_reset), 32'(tbl[i].rr));
      chk($sformatf("t%0d.is", i), 32'(iter_start), 32'(tbl[i].is));
      chk($sformatf("t%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("t%0d.done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("t%0d.conv", i), 32'(converged), 32'(tbl[i].conv));
      chk($sformatf("t%0d.to", i), 32'(timeout), 32'(tbl[i].to));
      chk($sformatf("t%0d.ic", i), 32'(iter_count), 32'(tbl[i].ic));
    end
    start = 1'b0; iter_done = 1'b0;

    // Gapped valid (every 3rd cycle), converges on pass 1.
    run(10, 1, 3, 1'b0, n_is, n_clr, n_en, lat);
    chk("gap.en", n_en, 8);   chk("gap.is", n_is, 0);   chk("gap.clr", n_clr, 1);
    chk("gap.lat", lat, 3);   chk("gap.conv", converged, 1); chk("gap.to", timeout, 0);
    chk("gap.ic", iter_count, 1);

    // Iteration limit without convergence.
    run(3, 0, 1, 1'b0, n_is, n_clr, n_en, lat);
    chk("lim.is", n_is, 2);   chk("lim.clr", n_clr, 3); chk("lim.en", n_en, 24);
    chk("lim.lat", lat, 3);   chk("lim.conv", converged, 0); chk("lim.to", timeout, 1);
    chk("lim.ic", iter_count, 3);

    // max_iter=0 acts as a limit of 1.
    run(0, 0, 1, 1'b0, n_is, n_clr, n_en, lat);
    chk("zero.is", n_is, 0);  chk("zero.clr", n_clr, 1); chk("zero.en", n_en, 8);
    chk("zero.to", timeout, 1); chk("zero.conv", converged, 0); chk("zero.ic", iter_count, 1);

    // Convergence on the limit iteration wins over timeout.
    run(2, 2, 1, 1'b0, n_is, n_clr, n_en, lat);
    chk("both.is", n_is, 1);  chk("both.conv", converged, 1); chk("both.to", timeout, 0);
    chk("both.ic", iter_count, 2);

    // start and iter_done in EVAL, start in the DONE cycle: all ignored.
    run(2, 0, 1, 1'b1, n_is, n_clr, n_en, lat);
    chk("mis.is", n_is, 1);   chk("mis.clr", n_clr, 2); chk("mis.en", n_en, 16);
    chk("mis.to", timeout, 1); chk("mis.conv", converged, 0); chk("mis.ic", iter_count, 2);

    // Asynchronous reset mid-EVAL of the second pass at cent_num=4.
    @(negedge clk);
    max_iter = IW'(5); start = 1'b1; new_centroid_valid = 1'b1; has_converged = 1'b0;
    idc = -1; found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      iter_done = (idc == 0);
      if (idc >= 0) idc--;
      #1;
      if (iter_start) idc = 1;
      if (iter_count == 1 && convergence_reg_en && cent_num == 3'd4) found = 1'b1;
    end
    chk("rst.reached_cent4", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst.cent", 32'(cent_num), 32'd0);     chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.en", 32'(convergence_reg_en), 32'd0);
    chk("rst.rr", 32'(convergence_reg_reset), 32'd1);
    chk("rst.ic", 32'(iter_count), 32'd0);     chk("rst.is", 32'(iter_start), 32'd0);
    chk("rst.done", 32'(done), 32'd0);         chk("rst.to", 32'(timeout), 32'd0);
    chk("rst.conv", 32'(converged), 32'd0);
    @(negedge clk);
    rst = 1'b0; new_centroid_valid = 1'b0; iter_done = 1'b0;
    run(10, 1, 1, 1'b0, n_is, n_clr, n_en, lat);
    chk("post.en", n_en, 8);  chk("post.ic", iter_count, 1); chk("post.conv", converged, 1);
    chk("post.lat", lat, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
